// File: rtl/add_4_reg_pkg.sv
// rtl/add_4_reg_pkg.sv - shared widths, reset value and result type for the registered adder
package add_4_pkg;
  localparam int ADD_W_DEFAULT = 4;
  localparam logic RST_VAL = 1'b0;

  typedef logic [ADD_W_DEFAULT:0] sum_t;
endpackage

// File: rtl/add_4_reg_if.sv
// rtl/add_4_reg_if.sv - operand/result bundle of the registered adder; ovf exists only with ADD_4_REG_OVF_EN
interface add_4_reg_if
  import add_4_pkg::*;
#(
  parameter int WIDTH = ADD_W_DEFAULT
);
  logic [WIDTH-1:0] add_0;
  logic [WIDTH-1:0] add_1;
  logic             c_in;
  logic [WIDTH-1:0] out;
  logic             c_out;
`ifdef ADD_4_REG_OVF_EN
  logic             ovf;

  modport master (output add_0, add_1, c_in, input out, c_out, ovf);
  modport slave  (input add_0, add_1, c_in, output out, c_out, ovf);
`else
  modport master (output add_0, add_1, c_in, input out, c_out);
  modport slave  (input add_0, add_1, c_in, output out, c_out);
`endif
endinterface

// File: rtl/add_4_reg_full_adder_1b.sv
// rtl/add_4_reg_full_adder_1b.sv - one combinational full-adder cell of the ripple chain
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/add_4_reg.sv
// rtl/add_4_reg.sv - ripple-carry adder with registered sum/carry; ADD_4_REG_OVF_EN adds a registered ovf
module add_4_reg
  import add_4_pkg::*;
#(
  parameter int WIDTH = ADD_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  add_4_reg_if.slave bus
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_out;
  logic             r_c_out;

  assign w_carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1b u_fa (
      .a  (bus.add_0[i]),
      .b  (bus.add_1[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= {WIDTH{RST_VAL}};
      r_c_out <= RST_VAL;
    end else begin
      r_out   <= w_sum;
      r_c_out <= w_carry[WIDTH];
    end
  end

  assign bus.out   = r_out;
  assign bus.c_out = r_c_out;

`ifdef ADD_4_REG_OVF_EN
  logic r_ovf;

  // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= RST_VAL;
    end else begin
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_add_4_reg.sv
// tb/tb_add_4_reg.sv - directed, reset, random and exhaustive checks of add_4_reg
module tb_add_4_reg;
  import add_4_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  logic pend;
  sum_t pend_exp;
  logic pend_ovf;

  add_4_reg_if #(.WIDTH(4)) bus ();

  add_4_reg #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic sum_t model_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
    return sum_t'(a) + sum_t'(b) + sum_t'(c);
  endfunction

  function automatic logic model_ovf(input logic [3:0] a, input logic [3:0] b, input logic c);
    int sa;
    int sb;
    int s;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    s  = sa + sb + int'(c);
    return (s > 7) || (s < -8);
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    bus.add_0 = a;
    bus.add_1 = b;
    bus.c_in  = c;
  endtask

  task automatic vec(input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [3:0] exp_out, input logic exp_c, input logic exp_ovf,
                     input string tag);
    @(negedge clk);
    drive(a, b, c);
    @(negedge clk);
    check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    check({tag, "_cout"}, 32'(bus.c_out), 32'(exp_c));
`ifdef ADD_4_REG_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`endif
  endtask

  task automatic pipe_step(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
    @(negedge clk);
    if (pend) begin
      check(tag, 32'({bus.c_out, bus.out}), 32'(pend_exp));
`ifdef ADD_4_REG_OVF_EN
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(pend_ovf));
`endif
    end
    drive(a, b, c);
    pend_exp = model_sum(a, b, c);
    pend_ovf = model_ovf(a, b, c);
    pend     = 1'b1;
  endtask

  initial begin
    logic [8:0] idx;
    n_checks = 0;
    n_fails  = 0;
    pend     = 1'b0;
    pend_exp = '0;
    pend_ovf = 1'b0;
    rst      = 1'b1;
    drive(4'h0, 4'h0, 1'b0);

    #2;
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_cout", 32'(bus.c_out), 32'h0);
`ifdef ADD_4_REG_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    vec(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, "one");
    vec(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "wrap");
    vec(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "max");
    vec(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, "ovf_pos");
    vec(4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1, "ovf_neg");
    vec(4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, "load_a");

    // Inputs moving between edges must not disturb the registered result.
    drive(4'h5, 4'h5, 1'b0);
    #2;
    check("hold_out", 32'(bus.out), 32'hA);

    // Reset asserted mid-cycle clears at once and discards the pending sum.
    rst = 1'b1;
    drive(4'h3, 4'h4, 1'b1);
    #1;
    check("async_rst_out", 32'(bus.out), 32'h0);
    check("async_rst_cout", 32'(bus.c_out), 32'h0);
    @(negedge clk);
    check("rst_held_out", 32'(bus.out), 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out", 32'(bus.out), 32'h8);
    check("post_rst_cout", 32'(bus.c_out), 32'h0);

    for (int i = 0; i < 1000; i++) begin
      pipe_step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
    end
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      pipe_step(idx[3:0], idx[7:4], idx[8], "sweep");
    end
    pipe_step(4'h0, 4'h0, 1'b0, "flush");
    @(negedge clk);
    check("flush_last", 32'({bus.c_out, bus.out}), 32'(pend_exp));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
